fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the write port of one FIFO among REQ_NUM requesters. Each requester presents bursts terminated by a last flag. The arbiter grants one requester at a time, holds the grant for the whole burst (capped at MAX_BURST beats) and throttles on the FIFO full flag. It sits directly in front of the FIFO write side, in the FIFO's write clock domain.

---
 rtl/fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a FIFO write port: burst-locked grants, MAX_BURST cap, full throttle.
// Optional idle-grant revocation is compiled in with `define ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
  parameter  int DATA_BITS = 32,
  parameter  int REQ_NUM   = 4,
  parameter  int MAX_BURST = 16,
  parameter  int TIMEOUT   = 8,
  localparam int ID_W      = $clog2(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           req_valid,
  input  logic [REQ_NUM-1:0]           req_last,
  input  logic [REQ_NUM*DATA_BITS-1:0] req_data,
  output logic [REQ_NUM-1:0]           req_ready,
  input  logic                         fifo_full_w,
  output logic                         fifo_en_w,
  output logic [DATA_BITS-1:0]         fifo_data_w,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
);

  localparam logic [ID_W:0] NREQ      = (ID_W+1)'(REQ_NUM);
  localparam logic [ID_W:0] LAST_ID   = (ID_W+1)'(REQ_NUM - 1);
  localparam logic [8:0]    BURST_LIM = 9'(MAX_BURST);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] grant_id_q;
  logic [7:0]      beat_cnt_q;
  logic            busy_q;

  logic [REQ_NUM-1:0] rot;
  logic [ID_W-1:0]    pos;
  logic [ID_W:0]      sum;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    next_ptr;
  logic               lock;
  logic               sel_valid;
  logic               beat;
  logic               burst_end;
  logic               release_beat;
  logic               to_hit;

  // Rotate requests so the search always starts at bit 0, then map back to an absolute index.
  always_comb begin
    rot = REQ_NUM'({req_valid, req_valid} >> rr_ptr_q);
    pos = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (rot[k]) pos = ID_W'(k);
    end
    sum = {1'b0, rr_ptr_q} + {1'b0, pos};
    if (sum >= NREQ) sum = sum - NREQ;
    winner = sum[ID_W-1:0];
  end

  assign next_ptr     = ({1'b0, grant_id_q} == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
  assign lock         = (state_q == LOCK);
  assign sel_valid    = req_valid[grant_id_q];
  assign beat         = lock & sel_valid & ~fifo_full_w;
  assign burst_end    = (({1'b0, beat_cnt_q} + 9'd1) == BURST_LIM);
  assign release_beat = beat & (req_last[grant_id_q] | burst_end);

  assign fifo_en_w   = beat;
  assign fifo_data_w = req_data[grant_id_q*DATA_BITS +: DATA_BITS];
  assign req_ready   = (lock & ~fifo_full_w) ? ({{(REQ_NUM-1){1'b0}}, 1'b1} << grant_id_q) : '0;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt_q;

  // Counts idle cycles of the granted requester; a stalled-by-full cycle neither counts nor clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                to_cnt_q <= '0;
    else if (!lock || beat)    to_cnt_q <= '0;
    else if (!sel_valid)       to_cnt_q <= to_cnt_q + 8'd1;
  end

  assign to_hit = lock & ~sel_valid & (to_cnt_q == TO_LIM);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            grant_id_q <= winner;
            beat_cnt_q <= '0;
            state_q    <= LOCK;
            busy_q     <= 1'b1;
          end
        end
        LOCK: begin
          if (release_beat || to_hit) begin
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end else if (beat && beat_cnt_q != 8'hFF) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester beat tables feed the DUT, a queue holds the expected FIFO writes.
module tb_fifo_wr_arbiter;
  localparam int DW = 32;
  localparam int RN = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [RN-1:0]    req_valid = '0;
  logic [RN-1:0]    req_last = '0;
  logic [RN*DW-1:0] req_data = '0;
  logic [RN-1:0]    req_ready;
  logic             fifo_full_w = 1'b0;
  logic             fifo_en_w;
  logic [DW-1:0]    fifo_data_w;
  logic [IW-1:0]    grant_id;
  logic             busy;

  fifo_wr_arbiter #(.DATA_BITS(DW), .REQ_NUM(RN), .MAX_BURST(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_full_w(fifo_full_w), .fifo_en_w(fifo_en_w),
    .fifo_data_w(fifo_data_w), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0]   rq_data [RN][64];
  logic          rq_last [RN][64];
  int            rq_len  [RN];
  int            rq_ptr  [RN];
  logic [31:0]   exp_data[$];
  logic [IW-1:0] exp_id[$];
  int            beat_cyc[$];
  int            cyc = 0;
  int            full_lo = 0, full_hi = 0;
  int            passed = 0, failed = 0, total = 0;
  int            t0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // mode: 0 = no last, 1 = last on final beat, 2 = last on every beat
  task automatic load(input int r, input int n, input int mode, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      rq_data[r][rq_len[r]] = base + 32'(k);
      rq_last[r][rq_len[r]] = (mode == 2) || (mode == 1 && k == n - 1);
      rq_len[r]++;
    end
  endtask

  task automatic expect_beats(input int r, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      exp_data.push_back(base + 32'(k));
      exp_id.push_back(IW'(r));
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < RN; i++) begin
      rq_len[i] = 0;
      rq_ptr[i] = 0;
    end
    beat_cyc.delete();
  endtask

  // One cycle: drive at the falling edge, sample just after, account for the handshake taken at the next rising edge.
  task automatic cycle();
    @(negedge clk);
    fifo_full_w = (cyc >= full_lo) && (cyc < full_hi);
    for (int i = 0; i < RN; i++) begin
      if (rq_ptr[i] < rq_len[i]) begin
        req_valid[i]           = 1'b1;
        req_last[i]            = rq_last[i][rq_ptr[i]];
        req_data[i*DW +: DW]   = rq_data[i][rq_ptr[i]];
      end else begin
        req_valid[i]           = 1'b0;
        req_last[i]            = 1'b0;
        req_data[i*DW +: DW]   = '0;
      end
    end
    #1;
    if (fifo_full_w) begin
      chk("full_en", {31'b0, fifo_en_w}, 32'd0);
      chk("full_ready", {28'b0, req_ready}, 32'd0);
    end
    if (fifo_en_w) begin
      beat_cyc.push_back(cyc);
      if (exp_data.size() == 0) chk("unexpected_beat", {31'b0, fifo_en_w}, 32'd0);
      else begin
        chk("data", fifo_data_w, exp_data.pop_front());
        chk("grant", {30'b0, grant_id}, {30'b0, exp_id.pop_front()});
      end
    end
    for (int i = 0; i < RN; i++) begin
      if (req_valid[i] && req_ready[i]) rq_ptr[i]++;
    end
    cyc++;
  endtask

  task automatic run_until_done(input int limit);
    int n;
    n = 0;
    while (exp_data.size() > 0 && n < limit) begin
      cycle();
      n++;
    end
    chk("drain", exp_data.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < RN; i++) begin
      rq_len[i] = 0;
      rq_ptr[i] = 0;
    end
    // Reset state
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_en", {31'b0, fifo_en_w}, 32'd0);
    chk("rst_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_gid", {30'b0, grant_id}, 32'd0);
    do_reset();

    // Single requester 2, three beats A,B,C
    clear_reqs();
    load(2, 3, 1, 32'hA);
    expect_beats(2, 32'hA, 3);
    t0 = cyc;
    run_until_done(20);
    chk("t1_nbeats", beat_cyc.size(), 32'd3);
    chk("t1_first", beat_cyc[0] - t0, 32'd1);
    chk("t1_last", beat_cyc[2] - t0, 32'd3);
    cycle();
    chk("t1_idle_busy", {31'b0, busy}, 32'd0);
    // rr_ptr now 3: requester 3 wins over requester 0
    clear_reqs();
    load(0, 1, 1, 32'h100);
    load(3, 1, 1, 32'h300);
    expect_beats(3, 32'h300, 1);
    expect_beats(0, 32'h100, 1);
    run_until_done(20);

    // All four continuously valid with one-beat bursts
    do_reset();
    clear_reqs();
    for (int i = 0; i < RN; i++) load(i, 2, 2, 32'h2000 + 32'(i * 16));
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < RN; i++) expect_beats(i, 32'h2000 + 32'(i * 16 + b), 1);
    t0 = cyc;
    run_until_done(40);
    chk("t2_first", beat_cyc[0] - t0, 32'd1);
    for (int k = 1; k < 8; k++) chk("t2_gap", beat_cyc[k] - beat_cyc[k-1], 32'd2);

    // 20-beat burst cut at 16, requester 3 interleaves
    clear_reqs();
    load(1, 20, 1, 32'h11000);
    load(3, 2, 1, 32'h33000);
    expect_beats(1, 32'h11000, 16);
    expect_beats(3, 32'h33000, 2);
    expect_beats(1, 32'h11010, 4);
    run_until_done(60);

    // FIFO full for 5 cycles mid-burst
    clear_reqs();
    load(0, 10, 1, 32'h4400);
    expect_beats(0, 32'h4400, 10);
    t0 = cyc;
    full_lo = t0 + 4;
    full_hi = t0 + 9;
    run_until_done(40);
    full_lo = 0;
    full_hi = 0;
    chk("t4_nbeats", beat_cyc.size(), 32'd10);
    chk("t4_resume", beat_cyc[3] - t0, 32'd9);
    chk("t4_last", beat_cyc[9] - t0, 32'd15);

    // Granted requester goes idle after 2 beats
    clear_reqs();
    load(1, 2, 0, 32'h5500);
    load(0, 1, 1, 32'h5000);
    expect_beats(1, 32'h5500, 2);
    t0 = cyc;
`ifdef ARB_TIMEOUT_EN
    expect_beats(0, 32'h5000, 1);
    run_until_done(40);
    chk("t5_to_grant", beat_cyc[2] - t0, 32'd12);
`else
    repeat (120) cycle();
    chk("t5_hold_busy", {31'b0, busy}, 32'd1);
    chk("t5_hold_gid", {30'b0, grant_id}, 32'd1);
    chk("t5_hold_beats", beat_cyc.size(), 32'd2);
    load(1, 1, 1, 32'h5502);
    expect_beats(1, 32'h5502, 1);
    expect_beats(0, 32'h5000, 1);
    run_until_done(20);
`endif

    // Reset in the middle of a burst
    clear_reqs();
    load(2, 8, 1, 32'h6600);
    expect_beats(2, 32'h6600, 2);
    repeat (3) cycle();
    @(posedge clk);
    #2;
    chk("t6_pre_busy", {31'b0, busy}, 32'd1);
    chk("t6_pre_en", {31'b0, fifo_en_w}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_en", {31'b0, fifo_en_w}, 32'd0);
    chk("t6_rst_ready", {28'b0, req_ready}, 32'd0);
    chk("t6_rst_drain", exp_data.size(), 32'd0);
    clear_reqs();
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    load(3, 1, 1, 32'h7300);
    load(0, 1, 1, 32'h7000);
    expect_beats(0, 32'h7000, 1);
    expect_beats(3, 32'h7300, 1);
    run_until_done(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
